// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: stall/flush/bubble handling plus the multi-cycle EX scratch
// state that is fed back to EX while it stalls. Define EX_MEM_HILO_EN to add a HI/LO write path.
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     ex_des_addr_in,
    input  logic                  ex_des_exist_in,
    input  logic [DATA_W-1:0]     ex_des_data_in,
    input  logic [CNT_W-1:0]      ex_cnt_in,
    input  logic [2*DATA_W-1:0]   ex_part_in,
`ifdef EX_MEM_HILO_EN
    input  logic                  ex_hilo_we_in,
    input  logic [DATA_W-1:0]     ex_hi_in,
    input  logic [DATA_W-1:0]     ex_lo_in,
    output logic                  mem_hilo_we_out,
    output logic [DATA_W-1:0]     mem_hi_out,
    output logic [DATA_W-1:0]     mem_lo_out,
`endif
    output logic [ADDR_W-1:0]     mem_des_addr_out,
    output logic                  mem_des_exist_out,
    output logic [DATA_W-1:0]     mem_des_data_out,
    output logic [CNT_W-1:0]      ex_cnt_out,
    output logic [2*DATA_W-1:0]   ex_part_out,
    output logic [15:0]           bubble_cnt_out
);

    localparam logic [15:0] BCNT_MAX = 16'hFFFF;

    logic [ADDR_W-1:0]   addr_d, addr_q;
    logic                exist_d, exist_q;
    logic [DATA_W-1:0]   data_d, data_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [2*DATA_W-1:0] part_d, part_q;
    logic [15:0]         bcnt_d, bcnt_q;
`ifdef EX_MEM_HILO_EN
    logic                hilo_we_d, hilo_we_q;
    logic [DATA_W-1:0]   hi_d, hi_q, lo_d, lo_q;
`endif

    // Only the EX and MEM stall bits matter to this register.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    always_comb begin
        addr_d  = addr_q;
        exist_d = exist_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        bcnt_d  = bcnt_q;
`ifdef EX_MEM_HILO_EN
        hilo_we_d = hilo_we_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`endif
        if (rst || flush) begin
            addr_d  = '0;
            exist_d = 1'b0;
            data_d  = '0;
            cnt_d   = '0;
            part_d  = '0;
            if (rst) bcnt_d = '0;
`ifdef EX_MEM_HILO_EN
            hilo_we_d = 1'b0;
            hi_d      = '0;
            lo_d      = '0;
`endif
        end else if (!stall[4]) begin
            // stall[4]=1 holds everything, which also absorbs the illegal stall[3]=0 case.
            if (stall[3]) begin
                addr_d  = '0;
                exist_d = 1'b0;
                data_d  = '0;
                cnt_d   = ex_cnt_in;
                part_d  = ex_part_in;
                if (bcnt_q != BCNT_MAX) bcnt_d = bcnt_q + 16'd1;
`ifdef EX_MEM_HILO_EN
                hilo_we_d = 1'b0;
                hi_d      = '0;
                lo_d      = '0;
`endif
            end else begin
                addr_d  = ex_des_addr_in;
                exist_d = ex_des_exist_in;
                data_d  = ex_des_data_in;
                cnt_d   = '0;
                part_d  = '0;
`ifdef EX_MEM_HILO_EN
                hilo_we_d = ex_hilo_we_in;
                hi_d      = ex_hi_in;
                lo_d      = ex_lo_in;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        exist_q <= exist_d;
        data_q  <= data_d;
        cnt_q   <= cnt_d;
        part_q  <= part_d;
        bcnt_q  <= bcnt_d;
`ifdef EX_MEM_HILO_EN
        hilo_we_q <= hilo_we_d;
        hi_q      <= hi_d;
        lo_q      <= lo_d;
`endif
    end

    assign mem_des_addr_out  = addr_q;
    assign mem_des_exist_out = exist_q;
    assign mem_des_data_out  = data_q;
    assign ex_cnt_out        = cnt_q;
    assign ex_part_out       = part_q;
    assign bubble_cnt_out    = bcnt_q;
`ifdef EX_MEM_HILO_EN
    assign mem_hilo_we_out = hilo_we_q;
    assign mem_hi_out      = hi_q;
    assign mem_lo_out      = lo_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: expected snapshots are queued as stimulus is driven
// and compared one cycle later against the registered outputs.
module tb_ex_mem_reg;

    typedef struct packed {
        logic [4:0]  addr;
        logic        exist;
        logic [31:0] data;
        logic [1:0]  cnt;
        logic [63:0] part;
        logic [15:0] bcnt;
    } snap_t;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_des_addr_in;
    logic        ex_des_exist_in;
    logic [31:0] ex_des_data_in;
    logic [1:0]  ex_cnt_in;
    logic [63:0] ex_part_in;
    logic [4:0]  mem_des_addr_out;
    logic        mem_des_exist_out;
    logic [31:0] mem_des_data_out;
    logic [1:0]  ex_cnt_out;
    logic [63:0] ex_part_out;
    logic [15:0] bubble_cnt_out;
`ifdef EX_MEM_HILO_EN
    logic        ex_hilo_we_in, mem_hilo_we_out;
    logic [31:0] ex_hi_in, ex_lo_in, mem_hi_out, mem_lo_out;
`endif

    snap_t got, exp_s;
    snap_t sb[$];
    int    total = 0;
    int    bad   = 0;
    logic [15:0] exp_bc = 16'd0;

    ex_mem_reg #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_des_addr_in(ex_des_addr_in), .ex_des_exist_in(ex_des_exist_in),
        .ex_des_data_in(ex_des_data_in), .ex_cnt_in(ex_cnt_in), .ex_part_in(ex_part_in),
`ifdef EX_MEM_HILO_EN
        .ex_hilo_we_in(ex_hilo_we_in), .ex_hi_in(ex_hi_in), .ex_lo_in(ex_lo_in),
        .mem_hilo_we_out(mem_hilo_we_out), .mem_hi_out(mem_hi_out), .mem_lo_out(mem_lo_out),
`endif
        .mem_des_addr_out(mem_des_addr_out), .mem_des_exist_out(mem_des_exist_out),
        .mem_des_data_out(mem_des_data_out), .ex_cnt_out(ex_cnt_out),
        .ex_part_out(ex_part_out), .bubble_cnt_out(bubble_cnt_out)
    );

    assign got = {mem_des_addr_out, mem_des_exist_out, mem_des_data_out,
                  ex_cnt_out, ex_part_out, bubble_cnt_out};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The stall controller stalls contiguously, so MEM never stalls while EX runs.
    always @(negedge clk) begin
        if (rst !== 1'b1)
            assert (!(stall[4] === 1'b1 && stall[3] === 1'b0))
            else $error("illegal stall vector %b", stall);
    end

    function automatic snap_t mk(input logic [4:0] a, input logic e, input logic [31:0] d,
                                 input logic [1:0] c, input logic [63:0] p, input logic [15:0] b);
        mk = {a, e, d, c, p, b};
    endfunction

    task automatic drive(input logic [5:0] s, input logic f, input logic [4:0] a, input logic e,
                         input logic [31:0] d, input logic [1:0] c, input logic [63:0] p);
        stall = s; flush = f; ex_des_addr_in = a; ex_des_exist_in = e;
        ex_des_data_in = d; ex_cnt_in = c; ex_part_in = p;
`ifdef EX_MEM_HILO_EN
        ex_hilo_we_in = 1'b0; ex_hi_in = '0; ex_lo_in = '0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(6'b001111, 1'b1, 5'd9, 1'b1, 32'hDEADBEEF, 2'd3, 64'hFFFF);
        exp_bc = 16'd0;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(5'd0, 1'b0, 32'd0, 2'd0, 64'd0, 16'd0));
            tick();
            exp_s = sb.pop_front(); total++;
            if (got !== exp_s) begin
                bad++; $display("FAIL reset[%0d] got=%h exp=%h", i, got, exp_s);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_advance();
        logic [4:0] a; logic e; logic [31:0] d;
        drive(6'b000000, 1'b0, 5'd3, 1'b1, 32'h12345678, 2'd2, 64'h55);
        sb.push_back(mk(5'd3, 1'b1, 32'h12345678, 2'd0, 64'd0, exp_bc));
        tick();
        exp_s = sb.pop_front(); total++;
        if (got !== exp_s) begin bad++; $display("FAIL advance got=%h exp=%h", got, exp_s); end
        for (int i = 0; i < 4; i++) begin
            a = 5'($urandom); e = 1'($urandom); d = $urandom;
            drive(6'b000000, 1'b0, a, e, d, 2'($urandom), {$urandom, $urandom});
            sb.push_back(mk(a, e, d, 2'd0, 64'd0, exp_bc));
            tick();
            exp_s = sb.pop_front(); total++;
            if (got !== exp_s) begin
                bad++; $display("FAIL advance_rand[%0d] got=%h exp=%h", i, got, exp_s);
            end
        end
    endtask

    task automatic test_bubble();
        for (int i = 0; i < 3; i++) begin
            drive(6'b001111, 1'b0, 5'd4, 1'b1, 32'h0BAD0BAD, 2'd1, 64'hA5);
            exp_bc = exp_bc + 16'd1;
            sb.push_back(mk(5'd0, 1'b0, 32'd0, 2'd1, 64'hA5, exp_bc));
            tick();
            exp_s = sb.pop_front(); total++;
            if (got !== exp_s) begin
                bad++; $display("FAIL bubble[%0d] got=%h exp=%h", i, got, exp_s);
            end
        end
        drive(6'b000000, 1'b0, 5'd9, 1'b1, 32'h0000CAFE, 2'd2, 64'h77);
        sb.push_back(mk(5'd9, 1'b1, 32'h0000CAFE, 2'd0, 64'd0, exp_bc));
        tick();
        exp_s = sb.pop_front(); total++;
        if (got !== exp_s) begin bad++; $display("FAIL bubble_release got=%h exp=%h", got, exp_s); end
    endtask

    task automatic test_hold();
        drive(6'b000000, 1'b0, 5'd7, 1'b1, 32'hFF, 2'd0, 64'd0);
        sb.push_back(mk(5'd7, 1'b1, 32'hFF, 2'd0, 64'd0, exp_bc));
        tick();
        exp_s = sb.pop_front(); total++;
        if (got !== exp_s) begin bad++; $display("FAIL hold_load got=%h exp=%h", got, exp_s); end
        for (int i = 0; i < 3; i++) begin
            drive(6'b011111, 1'b0, 5'd12, 1'b0, 32'h11111111 * i, 2'd3, 64'hBEEF);
            sb.push_back(mk(5'd7, 1'b1, 32'hFF, 2'd0, 64'd0, exp_bc));
            tick();
            exp_s = sb.pop_front(); total++;
            if (got !== exp_s) begin
                bad++; $display("FAIL hold[%0d] got=%h exp=%h", i, got, exp_s);
            end
        end
        // Scratch state saved by a bubble must also survive a MEM stall.
        drive(6'b001111, 1'b0, 5'd1, 1'b1, 32'h1, 2'd3, 64'h1234_0000_5678);
        exp_bc = exp_bc + 16'd1;
        sb.push_back(mk(5'd0, 1'b0, 32'd0, 2'd3, 64'h1234_0000_5678, exp_bc));
        drive(6'b001111, 1'b0, 5'd1, 1'b1, 32'h1, 2'd3, 64'h1234_0000_5678);
        tick();
        drive(6'b011111, 1'b0, 5'd2, 1'b1, 32'h2, 2'd1, 64'h9);
        sb.push_back(mk(5'd0, 1'b0, 32'd0, 2'd3, 64'h1234_0000_5678, exp_bc));
        for (int i = 0; i < 2; i++) begin
            if (i == 1) tick();
            exp_s = sb.pop_front(); total++;
            if (got !== exp_s) begin
                bad++; $display("FAIL hold_scratch[%0d] got=%h exp=%h", i, got, exp_s);
            end
        end
    endtask

    task automatic test_flush();
        drive(6'b001111, 1'b0, 5'd5, 1'b1, 32'h55, 2'd2, 64'hF00D);
        exp_bc = exp_bc + 16'd1;
        sb.push_back(mk(5'd0, 1'b0, 32'd0, 2'd2, 64'hF00D, exp_bc));
        tick();
        drive(6'b001111, 1'b1, 5'd6, 1'b1, 32'h66, 2'd1, 64'hAB);
        sb.push_back(mk(5'd0, 1'b0, 32'd0, 2'd0, 64'd0, exp_bc));
        tick();
        drive(6'b000000, 1'b0, 5'd8, 1'b1, 32'h88, 2'd0, 64'd0);
        sb.push_back(mk(5'd8, 1'b1, 32'h88, 2'd0, 64'd0, exp_bc));
        tick();
        drive(6'b000000, 1'b1, 5'd10, 1'b1, 32'hAA, 2'd1, 64'h1);
        sb.push_back(mk(5'd0, 1'b0, 32'd0, 2'd0, 64'd0, exp_bc));
        tick();
        // Drain the three post-check entries; first one was pushed before the flush step.
        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            exp_s = sb.pop_front();
            if (i == 3) begin
                total++;
                if (got !== exp_s) begin
                    bad++; $display("FAIL flush_advance got=%h exp=%h", got, exp_s);
                end
            end
        end
        drive(6'b001111, 1'b1, 5'd6, 1'b1, 32'h66, 2'd1, 64'hAB);
        sb.push_back(mk(5'd0, 1'b0, 32'd0, 2'd0, 64'd0, exp_bc));
        tick();
        exp_s = sb.pop_front(); total++;
        if (got !== exp_s) begin bad++; $display("FAIL flush_bubble got=%h exp=%h", got, exp_s); end
    endtask

    task automatic test_saturate();
        int guard = 0;
        drive(6'b001111, 1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 64'd0);
        while (exp_bc != 16'hFFFE && guard < 70000) begin
            tick();
            exp_bc = exp_bc + 16'd1;
            guard++;
        end
        sb.push_back(mk(5'd0, 1'b0, 32'd0, 2'd0, 64'd0, 16'hFFFE));
        exp_s = sb.pop_front(); total++;
        if (got !== exp_s) begin bad++; $display("FAIL sat_fffe got=%h exp=%h", got, exp_s); end
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(5'd0, 1'b0, 32'd0, 2'd0, 64'd0, 16'hFFFF));
            tick();
            exp_s = sb.pop_front(); total++;
            if (got !== exp_s) begin
                bad++; $display("FAIL sat[%0d] got=%h exp=%h", i, got, exp_s);
            end
        end
        exp_bc = 16'hFFFF;
        rst = 1'b1;
        sb.push_back(mk(5'd0, 1'b0, 32'd0, 2'd0, 64'd0, 16'd0));
        tick();
        rst = 1'b0;
        exp_s = sb.pop_front(); total++;
        if (got !== exp_s) begin bad++; $display("FAIL sat_reset got=%h exp=%h", got, exp_s); end
    endtask

    initial begin
        rst = 1'b1;
        drive(6'b000000, 1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 64'd0);
        test_reset();
        test_advance();
        test_bubble();
        test_hold();
        test_flush();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
